// File: rtl/feynman_chain_decoder_if.sv
// Handshake bundle for the Feynman-chain decoder: serial encoded input, word output.
interface feynman_chain_decoder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sync;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [15:0]      word_cnt;

    modport master (
        output sync, in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_data, word_cnt
    );

    modport slave (
        input  sync, in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_data, word_cnt
    );
endinterface

// File: rtl/feynman_chain_decoder.sv
// Undoes a cascaded CNOT-chain serial encoding (d[n] = e[n] ^ e[n-1]) and
// deserializes WIDTH bits LSB-first into a one-deep valid/ready output register.
module feynman_chain_decoder #(
    parameter int unsigned WIDTH = 8,
    parameter logic        SEED  = 1'b0
) (
    input logic                     clk,
    input logic                     rst,
    feynman_chain_decoder_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    r_cnt;
    logic             r_prev;
    logic [WIDTH-2:0] r_sr;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [15:0]      r_word_cnt;

    logic w_in_ready;
    logic w_accept;
    logic w_d;
    logic w_drain;

    // Final bit may only land when the output slot is empty or emptying this cycle.
    assign w_in_ready = (r_cnt != LAST) | ~r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready & ~bus.sync;
    assign w_d        = bus.in_bit ^ r_prev;
    assign w_drain    = r_out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_prev      <= SEED;
            r_sr        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            if (w_drain) begin
                r_word_cnt  <= r_word_cnt + 16'd1;
                r_out_valid <= 1'b0;
            end
            if (bus.sync) begin
                r_cnt  <= '0;
                r_prev <= SEED;
                r_sr   <= '0;
            end else if (w_accept) begin
                if (r_cnt == LAST) begin
                    r_out_data  <= {w_d, r_sr};
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                    r_prev      <= SEED;
                end else begin
                    r_sr[r_cnt] <= w_d;
                    r_cnt       <= r_cnt + CW'(1);
                    r_prev      <= bus.in_bit;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.word_cnt  = r_word_cnt;
endmodule

// File: tb/tb_feynman_chain_decoder.sv
// Directed bench for feynman_chain_decoder: WIDTH=4 with SEED=0 and SEED=1 instances.
module tb_feynman_chain_decoder;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    feynman_chain_decoder_if #(.WIDTH(4)) ba ();
    feynman_chain_decoder_if #(.WIDTH(4)) bb ();

    feynman_chain_decoder #(.WIDTH(4), .SEED(1'b0)) u_a (.clk(clk), .rst(rst), .bus(ba.slave));
    feynman_chain_decoder #(.WIDTH(4), .SEED(1'b1)) u_b (.clk(clk), .rst(rst), .bus(bb.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drv(input logic v, input logic b, input logic r, input logic s);
        ba.in_valid  = v;
        ba.in_bit    = b;
        ba.out_ready = r;
        ba.sync      = s;
    endtask

    task automatic b_drv(input logic v, input logic b, input logic r);
        bb.in_valid  = v;
        bb.in_bit    = b;
        bb.out_ready = r;
        bb.sync      = 1'b0;
    endtask

    // Sends four bits to instance A with the given out_ready, one per cycle.
    task automatic a_word(input logic [3:0] bits, input logic r);
        for (int i = 0; i < 4; i++) begin
            a_drv(1'b1, bits[i], r, 1'b0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        a_drv(1'b0, 1'b0, 1'b0, 1'b0);
        b_drv(1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", ba.out_valid, 0);
        chk("rst_out_data",  ba.out_data,  0);
        chk("rst_word_cnt",  ba.word_cnt,  0);
        chk("rst_in_ready",  ba.in_ready,  1);
        chk("rstB_out_valid", bb.out_valid, 0);
        rst = 1'b0;
        tick();

        // Single word: e = 1,0,0,1 -> d = 1,1,0,1 -> 4'hB
        a_drv(1'b1, 1'b1, 1'b1, 1'b0); tick();
        a_drv(1'b1, 1'b0, 1'b1, 1'b0); tick();
        a_drv(1'b1, 1'b0, 1'b1, 1'b0); tick();
        chk("w1_not_yet_valid", ba.out_valid, 0);
        a_drv(1'b1, 1'b1, 1'b1, 1'b0); tick();
        chk("w1_valid", ba.out_valid, 1);
        chk("w1_data",  ba.out_data,  4'hB);
        chk("w1_cnt_before_hs", ba.word_cnt, 0);
        a_drv(1'b0, 1'b0, 1'b1, 1'b0); tick();
        chk("w1_valid_dropped", ba.out_valid, 0);
        chk("w1_cnt", ba.word_cnt, 1);

        // Streaming 0000 then 1111 back-to-back -> 4'h0, 4'h1
        for (int i = 0; i < 8; i++) begin
            a_drv(1'b1, (i >= 4), 1'b1, 1'b0);
            chk("stream_in_ready", ba.in_ready, 1);
            tick();
            if (i == 3) begin
                chk("stream_w0_valid", ba.out_valid, 1);
                chk("stream_w0_data",  ba.out_data,  4'h0);
            end
        end
        chk("stream_w1_valid", ba.out_valid, 1);
        chk("stream_w1_data",  ba.out_data,  4'h1);
        a_drv(1'b0, 1'b0, 1'b1, 1'b0); tick();
        chk("stream_cnt", ba.word_cnt, 3);

        // Back-pressure: word B pending, next word 0000 stalls on its last bit
        a_word(4'b1001, 1'b1);
        chk("bp_first_data", ba.out_data, 4'hB);
        for (int i = 0; i < 3; i++) begin
            a_drv(1'b1, 1'b0, 1'b0, 1'b0);
            chk("bp_partial_ready", ba.in_ready, 1);
            tick();
        end
        a_drv(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("bp_last_blocked", ba.in_ready, 0);
        tick();
        chk("bp_hold_valid", ba.out_valid, 1);
        chk("bp_hold_data",  ba.out_data,  4'hB);
        chk("bp_hold_cnt",   ba.word_cnt,  3);
        a_drv(1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("bp_release_ready", ba.in_ready, 1);
        tick();
        chk("bp_swap_valid", ba.out_valid, 1);
        chk("bp_swap_data",  ba.out_data,  4'h0);
        chk("bp_swap_cnt",   ba.word_cnt,  4);
        a_drv(1'b0, 1'b0, 1'b1, 1'b0); tick();
        chk("bp_drained", ba.out_valid, 0);
        chk("bp_cnt", ba.word_cnt, 5);

        // Sync discards partial bits and the bit presented alongside it
        a_drv(1'b1, 1'b1, 1'b1, 1'b0); tick();
        a_drv(1'b1, 1'b1, 1'b1, 1'b0); tick();
        a_drv(1'b1, 1'b1, 1'b1, 1'b1); tick();
        a_word(4'b1001, 1'b1);
        chk("sync_valid", ba.out_valid, 1);
        chk("sync_data",  ba.out_data,  4'hB);
        a_drv(1'b0, 1'b0, 1'b1, 1'b0); tick();
        chk("sync_cnt", ba.word_cnt, 6);

        // Async reset mid-word with a pending word
        a_word(4'b1001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            a_drv(1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("ar_pending_valid", ba.out_valid, 1);
        a_drv(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", ba.out_valid, 0);
        chk("ar_out_data",  ba.out_data,  0);
        chk("ar_word_cnt",  ba.word_cnt,  0);
        rst = 1'b0;
        tick();
        a_word(4'b1001, 1'b1);
        chk("ar_next_data", ba.out_data, 4'hB);
        a_drv(1'b0, 1'b0, 1'b1, 1'b0); tick();
        chk("ar_next_cnt", ba.word_cnt, 1);

        // SEED=1: e = 1,0,0,1 -> d = 0,1,0,1 -> 4'hA, chain restarts each word
        for (int w = 0; w < 2; w++) begin
            b_drv(1'b1, 1'b1, 1'b1); tick();
            b_drv(1'b1, 1'b0, 1'b1); tick();
            b_drv(1'b1, 1'b0, 1'b1); tick();
            b_drv(1'b1, 1'b1, 1'b1); tick();
            chk("seed1_valid", bb.out_valid, 1);
            chk("seed1_data",  bb.out_data,  4'hA);
        end
        b_drv(1'b0, 1'b0, 1'b1); tick();
        chk("seed1_cnt", bb.word_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
